// File: rtl/amber_trap_pkg.sv
// Shared definitions for the amber trap sequencer: FSM encoding, cause codes,
// default SR file indices and the trap-counter saturation helper.
package amber_trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_LR    = 3'd1,
        ST_WR_CAUSE = 3'd2,
        ST_WR_BAD   = 3'd3,
        ST_REDIR    = 3'd4,
        ST_HALT     = 3'd5
    } trap_state_e;

    localparam logic [7:0] CAUSE_CAP_BOUNDS = 8'h01;
    localparam logic [7:0] CAUSE_CAP_PERM   = 8'h02;
    localparam logic [7:0] CAUSE_CAP_TAG    = 8'h03;
    localparam logic [7:0] CAUSE_ILLEGAL    = 8'h04;

    localparam int IDX_LR_DEF      = 0;
    localparam int IDX_CAUSE_DEF   = 1;
    localparam int IDX_BADADDR_DEF = 2;

    localparam logic [15:0] TRAP_CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == TRAP_CNT_MAX) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/amber_trap_capture.sv
// Trap capture register: latches the faulting cause/pc/badaddr on accept and
// precomputes the fetch redirect target from the vector base.
module amber_trap_capture
    import amber_trap_pkg::*;
#(
    parameter int ADDR_W    = 48,
    parameter int CAUSE_W   = 8,
    parameter int VEC_SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic [ADDR_W-1:0]  trap_pc,
    input  logic [ADDR_W-1:0]  trap_badaddr,
    input  logic [ADDR_W-1:0]  vec_base,
    output logic [CAUSE_W-1:0] cap_cause,
    output logic [ADDR_W-1:0]  cap_pc,
    output logic [ADDR_W-1:0]  cap_badaddr,
    output logic [ADDR_W-1:0]  cap_target
);

    logic [ADDR_W-1:0] vec_offset;
    logic [ADDR_W-1:0] target;

    // A zero stride collapses every cause onto the single vector at base.
    generate
        if (VEC_SHIFT == 0) begin : g_single_vec
            assign vec_offset = '0;
        end else begin : g_strided_vec
            assign vec_offset = ADDR_W'(trap_cause) << VEC_SHIFT;
        end
    endgenerate

    // Plain ADDR_W-bit add: the carry out is dropped so the target wraps.
    assign target = vec_base + vec_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cause   <= '0;
            cap_pc      <= '0;
            cap_badaddr <= '0;
            cap_target  <= '0;
        end else if (load) begin
            cap_cause   <= trap_cause;
            cap_pc      <= trap_pc;
            cap_badaddr <= trap_badaddr;
            cap_target  <= target;
        end
    end

endmodule

// File: rtl/amber_trap_seq.sv
// Trap sequencer: accepts one precise EX trap, flushes, writes LR/CAUSE/BADADDR
// into the SR file under grant control, then redirects fetch to the vector.
module amber_trap_seq
    import amber_trap_pkg::*;
#(
    parameter int ADDR_W      = 48,
    parameter int CAUSE_W     = 8,
    parameter int SR_IDX_W    = 4,
    parameter int IDX_LR      = IDX_LR_DEF,
    parameter int IDX_CAUSE   = IDX_CAUSE_DEF,
    parameter int IDX_BADADDR = IDX_BADADDR_DEF,
    parameter int VEC_SHIFT   = 0
) (
    input  logic                iw_clk,
    input  logic                iw_rst_n,
    input  logic                iw_trap_valid,
    output logic                ow_trap_ready,
    input  logic [CAUSE_W-1:0]  iw_trap_cause,
    input  logic [ADDR_W-1:0]   iw_trap_pc,
    input  logic [ADDR_W-1:0]   iw_trap_badaddr,
    input  logic [ADDR_W-1:0]   iw_vec_base,
    output logic                ow_flush,
    output logic                ow_sr_we,
    output logic [SR_IDX_W-1:0] ow_sr_idx,
    output logic [ADDR_W-1:0]   ow_sr_wdata,
    input  logic                iw_sr_gnt,
    output logic                ow_redir_valid,
    output logic [ADDR_W-1:0]   ow_redir_pc,
    output logic                ow_halt,
    output logic                ow_busy,
    output logic [15:0]         ow_trap_cnt
);

    trap_state_e        state_q, state_d;
    logic               accept;
    logic               flush_q;
    logic [15:0]        trap_cnt_q;
    logic [CAUSE_W-1:0] cap_cause;
    logic [ADDR_W-1:0]  cap_pc;
    logic [ADDR_W-1:0]  cap_badaddr;
    logic [ADDR_W-1:0]  cap_target;

    amber_trap_capture #(
        .ADDR_W    (ADDR_W),
        .CAUSE_W   (CAUSE_W),
        .VEC_SHIFT (VEC_SHIFT)
    ) u_capture (
        .clk          (iw_clk),
        .rst_n        (iw_rst_n),
        .load         (accept),
        .trap_cause   (iw_trap_cause),
        .trap_pc      (iw_trap_pc),
        .trap_badaddr (iw_trap_badaddr),
        .vec_base     (iw_vec_base),
        .cap_cause    (cap_cause),
        .cap_pc       (cap_pc),
        .cap_badaddr  (cap_badaddr),
        .cap_target   (cap_target)
    );

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q    <= ST_IDLE;
            flush_q    <= 1'b0;
            trap_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= accept;
            if (accept) begin
                trap_cnt_q <= sat_inc16(trap_cnt_q);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        ow_sr_we       = 1'b0;
        ow_sr_idx      = '0;
        ow_sr_wdata    = '0;
        ow_redir_valid = 1'b0;
        ow_redir_pc    = '0;
        case (state_q)
            ST_IDLE: begin
                if (iw_trap_valid) begin
                    accept  = 1'b1;
                    state_d = ST_WR_LR;
                end
            end
            ST_WR_LR, ST_WR_CAUSE, ST_WR_BAD: begin
                // A new trap here means the flush did not kill the trapping path:
                // stop writing at once and park in HALT.
                if (iw_trap_valid) begin
                    state_d = ST_HALT;
                end else begin
                    ow_sr_we = 1'b1;
                    case (state_q)
                        ST_WR_LR: begin
                            ow_sr_idx   = SR_IDX_W'(IDX_LR);
                            ow_sr_wdata = cap_pc;
                            if (iw_sr_gnt) state_d = ST_WR_CAUSE;
                        end
                        ST_WR_CAUSE: begin
                            ow_sr_idx   = SR_IDX_W'(IDX_CAUSE);
                            ow_sr_wdata = ADDR_W'(cap_cause);
                            if (iw_sr_gnt) state_d = ST_WR_BAD;
                        end
                        default: begin
                            ow_sr_idx   = SR_IDX_W'(IDX_BADADDR);
                            ow_sr_wdata = cap_badaddr;
                            if (iw_sr_gnt) state_d = ST_REDIR;
                        end
                    endcase
                end
            end
            ST_REDIR: begin
                // Any trap_valid seen here belongs to the pre-redirect stream.
                ow_redir_valid = 1'b1;
                ow_redir_pc    = cap_target;
                state_d        = ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ow_trap_ready = (state_q == ST_IDLE);
    assign ow_busy       = (state_q != ST_IDLE);
    assign ow_halt       = (state_q == ST_HALT);
    assign ow_flush      = flush_q;
    assign ow_trap_cnt   = trap_cnt_q;

endmodule
